// File: rtl/uart_fifo_ext.sv
// Purpose: UART byte buffer with selectable registered or first-word-fall-through read, fill count, watermarks, flush and sticky error flags.
// Latency: a write is visible in count one edge later; registered reads return data one edge after rd_en; FWFT shows the head word combinationally.
// Backpressure: writes are dropped when full (overflow) and reads are dropped when empty (underflow); flush and rst discard that cycle's requests.
module uart_fifo_ext #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);

    // Threshold constants sized to the count so the compares stay width-matched.
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_LVL);
    localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_LVL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // Status flags come only from the registered count, so they move on edges only.
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    // Acceptance is judged on start-of-cycle flags; rst and flush swallow requests.
    always_comb begin
        wr_acc = 1'b0;
        rd_acc = 1'b0;
        if (!rst && !flush) begin
            wr_acc = wr_en && !full;
            rd_acc = rd_en && !empty;
        end
    end

    // Storage array: no reset, flush leaves stale contents in place.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointers and fill count; the extra pointer MSB wraps naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags: a rejected request sets, clr_err clears, set wins; frozen during flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            overflow  <= (wr_en && full)  || (overflow  && !clr_err);
            underflow <= (rd_en && empty) || (underflow && !clr_err);
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            // Registered read: one-cycle rd_valid pulse per accepted pop, data held otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else if (flush) begin
                    rd_valid <= 1'b0;
                end else if (rd_acc) begin
                    rd_data  <= mem[rd_ptr[AW-1:0]];
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b0;
                end
            end
        end else begin : g_fwft_read
            // Head word is always on display; rd_en acknowledges and pops it.
            assign rd_data  = mem[rd_ptr[AW-1:0]];
            assign rd_valid = !empty;
        end
    endgenerate

endmodule
